// File: rtl/vector_cache_pkg.sv
// Shared types for the vector cache SRAM path: the SRAM command word and the
// read/write arbiter winner encoding.
package vector_cache_pkg;

    typedef struct packed {
        logic [8:0] addr;
        logic       mode;
        logic [1:0] byte_sel;
    } sram_inst_cmd_t;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_winner_e;

    function automatic arb_winner_e arb_other(input arb_winner_e w);
        return (w == ARB_RD) ? ARB_WR : ARB_RD;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Circular-buffer response FIFO with a combinationally visible head and an
// occupancy count one bit wider than the pointers.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/sram_req_arb.sv
// Read/write request arbiter in front of one sram_inst, with a credit-checked
// response FIFO. Define SRAM_REQ_ARB_PERF_CNT_EN to add the performance counters.
module sram_req_arb
    import vector_cache_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_vld,
    output logic                 rd_req_rdy,
    input  sram_inst_cmd_t       rd_req_cmd,
    input  logic [TAG_W-1:0]     rd_req_tag,
    input  logic                 wr_req_vld,
    output logic                 wr_req_rdy,
    input  sram_inst_cmd_t       wr_req_cmd,
    input  logic [31:0]          wr_req_data,
    output logic                 read_vld,
    output sram_inst_cmd_t       read_cmd,
    output logic                 write_vld,
    output sram_inst_cmd_t       write_cmd,
    output logic [31:0]          wr_data,
    input  logic [31:0]          rd_data,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [31:0]          rsp_data,
    output logic [TAG_W-1:0]     rsp_tag
`ifdef SRAM_REQ_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     conflict_cnt,
    output logic [CNT_W-1:0]     rd_credit_stall_cnt
`endif
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    // Handshake: a request transfers in any cycle where its vld and rdy are both high.
    logic              inflight_q, inflight_d;
    logic [TAG_W-1:0]  rtn_tag_q, rtn_tag_d;
    arb_winner_e       last_win_q, last_win_d;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic              credit_ok;
    logic              rd_elig;
    logic              wr_elig;
    logic              conflict;
    logic              grant_rd;
    logic              grant_wr;
    logic              fifo_push;
    logic              fifo_pop;
    logic [TAG_W+31:0] fifo_head;

    always_comb begin
        // Credit uses registered state only, so a same-cycle pop never frees a slot early.
        occupancy  = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
        credit_ok  = occupancy < (CW + 1)'(RSP_DEPTH);
        rd_elig    = !rst && rd_req_vld && credit_ok;
        wr_elig    = !rst && wr_req_vld;
        conflict   = rd_elig && wr_elig;
        grant_rd   = rd_elig && (!wr_elig || last_win_q == ARB_WR);
        grant_wr   = wr_elig && (!rd_elig || last_win_q == ARB_RD);
        last_win_d = conflict ? arb_other(last_win_q) : last_win_q;
        inflight_d = grant_rd;
        rtn_tag_d  = grant_rd ? rd_req_tag : rtn_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rtn_tag_q  <= '0;
            last_win_q <= ARB_RD;
        end else begin
            inflight_q <= inflight_d;
            rtn_tag_q  <= rtn_tag_d;
            last_win_q <= last_win_d;
        end
    end

    assign read_vld   = grant_rd;
    assign write_vld  = grant_wr;
    assign rd_req_rdy = grant_rd;
    assign wr_req_rdy = grant_wr;
    assign read_cmd   = rd_req_cmd;
    assign write_cmd  = wr_req_cmd;
    assign wr_data    = wr_req_data;

    assign fifo_push = inflight_q && !rst;
    assign rsp_vld   = !rst && (fifo_count != '0);
    assign fifo_pop  = rsp_vld && rsp_rdy;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (TAG_W + 32)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({rtn_tag_q, rd_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign rsp_data = fifo_head[31:0];
    assign rsp_tag  = fifo_head[TAG_W+31:32];

`ifdef SRAM_REQ_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (conflict && conflict_cnt_q != '1) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
        if (rd_req_vld && !credit_ok && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign conflict_cnt        = conflict_cnt_q;
    assign rd_credit_stall_cnt = stall_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_sram_req_arb.sv
// Bench for sram_req_arb: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_sram_req_arb;
    import vector_cache_pkg::*;

    localparam int TAG_W     = 4;
    localparam int RSP_DEPTH = 4;
    localparam int CNT_W     = 16;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               rd_req_vld;
    logic               rd_req_rdy;
    sram_inst_cmd_t     rd_req_cmd;
    logic [TAG_W-1:0]   rd_req_tag;
    logic               wr_req_vld;
    logic               wr_req_rdy;
    sram_inst_cmd_t     wr_req_cmd;
    logic [31:0]        wr_req_data;
    logic               read_vld;
    sram_inst_cmd_t     read_cmd;
    logic               write_vld;
    sram_inst_cmd_t     write_cmd;
    logic [31:0]        wr_data;
    logic [31:0]        rd_data;
    logic               rsp_vld;
    logic               rsp_rdy;
    logic [31:0]        rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
`ifdef SRAM_REQ_ARB_PERF_CNT_EN
    logic [CNT_W-1:0]   conflict_cnt;
    logic [CNT_W-1:0]   rd_credit_stall_cnt;
`endif

    sram_req_arb #(
        .TAG_W     (TAG_W),
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req_vld  (rd_req_vld),
        .rd_req_rdy  (rd_req_rdy),
        .rd_req_cmd  (rd_req_cmd),
        .rd_req_tag  (rd_req_tag),
        .wr_req_vld  (wr_req_vld),
        .wr_req_rdy  (wr_req_rdy),
        .wr_req_cmd  (wr_req_cmd),
        .wr_req_data (wr_req_data),
        .read_vld    (read_vld),
        .read_cmd    (read_cmd),
        .write_vld   (write_vld),
        .write_cmd   (write_cmd),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_data    (rsp_data),
        .rsp_tag     (rsp_tag)
`ifdef SRAM_REQ_ARB_PERF_CNT_EN
        ,
        .conflict_cnt        (conflict_cnt),
        .rd_credit_stall_cnt (rd_credit_stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    bit               in_rst;
    bit               in_rd_vld;
    sram_inst_cmd_t   in_rd_cmd;
    logic [TAG_W-1:0] in_rd_tag;
    bit               in_wr_vld;
    sram_inst_cmd_t   in_wr_cmd;
    logic [31:0]      in_wr_data;
    bit               in_rsp_rdy;

    // ---------------- model / scoreboard ----------------
    logic [TAG_W+31:0] exp_q[$];
    logic [31:0]       sram_mem [logic [8:0]];
    bit                m_last_wr;
    bit                m_infl;
    logic [TAG_W-1:0]  m_infl_tag;
    logic [31:0]       m_infl_data;
    longint            m_conf_cnt;
    longint            m_stall_cnt;

    bit                obs_rd;
    bit                obs_wr;
    bit                obs_rsp_vld;
    logic [TAG_W-1:0]  obs_rsp_tag;
    logic [31:0]       obs_rsp_data;
    sram_inst_cmd_t    obs_read_cmd;
    longint            obs_conf_cnt;

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step();
        bit credit;
        bit rd_el;
        bit wr_el;
        bit g_rd;
        bit g_wr;
        bit q_nonempty;
        @(negedge clk);
        rst         = in_rst;
        rd_req_vld  = in_rd_vld;
        rd_req_cmd  = in_rd_cmd;
        rd_req_tag  = in_rd_tag;
        wr_req_vld  = in_wr_vld;
        wr_req_cmd  = in_wr_cmd;
        wr_req_data = in_wr_data;
        rsp_rdy     = in_rsp_rdy;
        rd_data     = m_infl ? m_infl_data : $urandom;
        #1;
        q_nonempty = exp_q.size() != 0;
        credit = (exp_q.size() + int'(m_infl)) < RSP_DEPTH;
        rd_el  = !in_rst && in_rd_vld && credit;
        wr_el  = !in_rst && in_wr_vld;
        if (rd_el && wr_el) begin
            g_wr = !m_last_wr;
            g_rd = m_last_wr;
        end else begin
            g_rd = rd_el;
            g_wr = wr_el;
        end

        chk("read_vld",   64'(read_vld),   64'(g_rd));
        chk("write_vld",  64'(write_vld),  64'(g_wr));
        chk("rd_req_rdy", 64'(rd_req_rdy), 64'(g_rd));
        chk("wr_req_rdy", 64'(wr_req_rdy), 64'(g_wr));
        chk("issue_exclusive", 64'(read_vld && write_vld), 64'(0));
        chk("read_cmd",  64'(read_cmd),  64'(in_rd_cmd));
        chk("write_cmd", 64'(write_cmd), 64'(in_wr_cmd));
        chk("wr_data",   64'(wr_data),   64'(in_wr_data));
        if (!in_rst) begin
            chk("rsp_vld", 64'(rsp_vld), 64'(q_nonempty));
            if (q_nonempty) begin
                chk("rsp_data", 64'(rsp_data), 64'(exp_q[0][31:0]));
                chk("rsp_tag",  64'(rsp_tag),  64'(exp_q[0][TAG_W+31:32]));
            end
        end
`ifdef SRAM_REQ_ARB_PERF_CNT_EN
        chk("conflict_cnt",        64'(conflict_cnt),        64'(m_conf_cnt));
        chk("rd_credit_stall_cnt", 64'(rd_credit_stall_cnt), 64'(m_stall_cnt));
        obs_conf_cnt = longint'(conflict_cnt);
`endif
        obs_rd       = read_vld;
        obs_wr       = write_vld;
        obs_rsp_vld  = rsp_vld;
        obs_rsp_tag  = rsp_tag;
        obs_rsp_data = rsp_data;
        obs_read_cmd = read_cmd;

        if (in_rst) begin
            exp_q.delete();
            m_infl      = 1'b0;
            m_last_wr   = 1'b0;
            m_conf_cnt  = 0;
            m_stall_cnt = 0;
        end else begin
            if (rd_el && wr_el) begin
                m_last_wr = g_wr;
                if (m_conf_cnt < CNT_MAX) m_conf_cnt++;
            end
            if (in_rd_vld && !credit && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (q_nonempty && in_rsp_rdy) void'(exp_q.pop_front());
            if (m_infl) exp_q.push_back({m_infl_tag, rd_data});
            if (g_wr) sram_mem[in_wr_cmd.addr] = in_wr_data;
            m_infl = g_rd;
            if (g_rd) begin
                if (!sram_mem.exists(in_rd_cmd.addr)) sram_mem[in_rd_cmd.addr] = $urandom;
                m_infl_tag  = in_rd_tag;
                m_infl_data = sram_mem[in_rd_cmd.addr];
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        in_rd_vld  = 1'b0;
        in_wr_vld  = 1'b0;
        in_rsp_rdy = rdy;
        repeat (n) step();
    endtask

    task automatic rand_cmd(output sram_inst_cmd_t c);
        c.addr     = 9'($urandom_range(0, 511));
        c.mode     = 1'($urandom_range(0, 1));
        c.byte_sel = 2'($urandom_range(0, 3));
    endtask

    initial begin
        int grants;
        sram_inst_cmd_t c;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; rd_req_vld = 1'b0; wr_req_vld = 1'b0; rsp_rdy = 1'b0;
        rd_req_cmd = '0; rd_req_tag = '0; wr_req_cmd = '0; wr_req_data = '0; rd_data = '0;
        in_rd_cmd = '0; in_wr_cmd = '0; in_rd_tag = '0; in_wr_data = '0;
        m_infl = 1'b0; m_last_wr = 1'b0; m_conf_cnt = 0; m_stall_cnt = 0;

        // Reset
        in_rst = 1'b1;
        idle(2, 1'b0);
        in_rst = 1'b0;
        idle(1, 1'b0);
        chk("reset_rsp_vld", 64'(obs_rsp_vld), 64'(0));
        chk("reset_read_vld", 64'(obs_rd), 64'(0));

        // Write then read the same location
        c.addr = 9'h010; c.mode = 1'b0; c.byte_sel = 2'b01;
        in_wr_cmd = c; in_wr_data = 32'hDEADBEEF; in_wr_vld = 1'b1;
        step();
        chk("wr_grant", 64'(obs_wr), 64'(1));
        in_wr_vld = 1'b0;
        in_rd_cmd = c; in_rd_tag = 4'h3; in_rd_vld = 1'b1;
        step();
        chk("rd_grant", 64'(obs_rd), 64'(1));
        idle(1, 1'b0);
        chk("rsp_not_yet", 64'(obs_rsp_vld), 64'(0));
        idle(1, 1'b0);
        chk("rsp_vld_lat2", 64'(obs_rsp_vld), 64'(1));
        chk("rsp_data_lit", 64'(obs_rsp_data), 64'(32'hDEADBEEF));
        chk("rsp_tag_lit",  64'(obs_rsp_tag),  64'(4'h3));
        idle(2, 1'b1);

        // Continuous conflict: W,R,W,R,W,R
        for (int i = 0; i < 6; i++) begin
            rand_cmd(in_rd_cmd); rand_cmd(in_wr_cmd);
            in_rd_tag = 4'(i); in_wr_data = $urandom;
            in_rd_vld = 1'b1; in_wr_vld = 1'b1; in_rsp_rdy = 1'b1;
            step();
            chk("conflict_wr", 64'(obs_wr), 64'((i % 2) == 0));
            chk("conflict_rd", 64'(obs_rd), 64'((i % 2) == 1));
        end
        idle(1, 1'b1);
`ifdef SRAM_REQ_ARB_PERF_CNT_EN
        chk("conflict_cnt_lit", 64'(obs_conf_cnt), 64'(6));
`endif
        idle(3, 1'b1);

        // Credit backpressure
        grants = 0;
        in_rsp_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_rd_vld = 1'b1; in_rd_tag = 4'(grants); rand_cmd(in_rd_cmd);
            step();
            if (obs_rd) grants++;
        end
        chk("credit_grants", 64'(grants), 64'(4));
        chk("credit_blocked", 64'(obs_rd), 64'(0));
        in_rsp_rdy = 1'b1; in_rd_tag = 4'h4;
        step();
        chk("blocked_on_pop", 64'(obs_rd), 64'(0));
        chk("pop_tag0", 64'(obs_rsp_tag), 64'(0));
        step();
        chk("grant_after_pop", 64'(obs_rd), 64'(1));
        chk("pop_tag1", 64'(obs_rsp_tag), 64'(1));
        in_rd_vld = 1'b0;
        step();
        chk("pop_tag2", 64'(obs_rsp_tag), 64'(2));
        step();
        chk("pop_tag3", 64'(obs_rsp_tag), 64'(3));
        idle(3, 1'b1);

        // Simultaneous push/pop with three entries held
        in_rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_rd_vld = 1'b1; in_rd_tag = 4'(8 + i); rand_cmd(in_rd_cmd);
            step();
            chk("fill_grant", 64'(obs_rd), 64'(1));
        end
        in_rd_vld = 1'b0; in_rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pushpop_vld", 64'(obs_rsp_vld), 64'(1));
            chk("pushpop_tag", 64'(obs_rsp_tag), 64'(8 + i));
        end
        step();
        chk("pushpop_empty", 64'(obs_rsp_vld), 64'(0));

        // Reset with a read in flight
        in_rsp_rdy = 1'b0; in_rd_vld = 1'b1; in_rd_tag = 4'h5; rand_cmd(in_rd_cmd);
        step();
        chk("rst_flight_grant", 64'(obs_rd), 64'(1));
        in_rd_vld = 1'b0; in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1, 1'b1);
            chk("no_stale_rsp", 64'(obs_rsp_vld), 64'(0));
        end

        // Byte-mode read
        c.addr = 9'h0A5; c.mode = 1'b1; c.byte_sel = 2'b10;
        in_rd_cmd = c; in_rd_vld = 1'b1; in_wr_vld = 1'b0; in_rd_tag = 4'h7;
        step();
        chk("byte_grant", 64'(obs_rd), 64'(1));
        chk("byte_cmd", 64'(obs_read_cmd), 64'(12'h52E));
        chk("byte_no_write", 64'(obs_wr), 64'(0));
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_rst     = ($urandom_range(0, 79) == 0);
            in_rd_vld  = ($urandom_range(0, 3) != 0);
            in_wr_vld  = ($urandom_range(0, 2) == 0);
            in_rsp_rdy = ($urandom_range(0, 2) != 0);
            in_rd_tag  = 4'($urandom_range(0, 15));
            in_wr_data = $urandom;
            rand_cmd(in_rd_cmd);
            rand_cmd(in_wr_cmd);
            if ($urandom_range(0, 3) == 0) in_wr_cmd.addr = in_rd_cmd.addr;
            step();
        end
        in_rst = 1'b0;
        idle(8, 1'b1);
        chk("final_empty", 64'(obs_rsp_vld), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_req_arb.md
Name: sram_req_arb

Overview:
- Request front-end sitting directly upstream of each sram_inst in the sram_group.
- Accepts independent read and write request streams over valid/ready and issues at most one SRAM access per cycle, so read_vld and write_vld are never high together.
- Captures the 1-cycle-latency 32-bit read data with its tag into a response FIFO that is drained over valid/ready.

Parameters:
- TAG_W, 4, width of the read tag returned with each response.
- RSP_DEPTH, 4, response FIFO depth in entries; power of two, at least 2.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_req_vld  in  1  read request valid
- rd_req_rdy  out  1  read request accepted this cycle
- rd_req_cmd  in  sram_inst_cmd_t  addr[8:0], mode, byte_sel[1:0]
- rd_req_tag  in  TAG_W  tag echoed on the response
- wr_req_vld  in  1  write request valid
- wr_req_rdy  out  1  write request accepted this cycle
- wr_req_cmd  in  sram_inst_cmd_t  write command
- wr_req_data  in  32  write data
- read_vld  out  1  to sram_inst
- read_cmd  out  sram_inst_cmd_t  to sram_inst
- write_vld  out  1  to sram_inst
- write_cmd  out  sram_inst_cmd_t  to sram_inst
- wr_data  out  32  to sram_inst
- rd_data  in  32  from sram_inst, valid one cycle after read_vld
- rsp_vld  out  1  response FIFO head valid
- rsp_rdy  in  1  consumer ready
- rsp_data  out  32  head data
- rsp_tag  out  TAG_W  head tag

Behaviour:
- Eligibility:
  - Write eligible = wr_req_vld.
  - Read eligible = rd_req_vld && credit_ok.
  - credit_ok = (fifo_count + inflight) < RSP_DEPTH, where inflight is the registered read_vld of the previous cycle (0 or 1).
- Grant:
  - If only one request is eligible, it wins.
  - If both are eligible (conflict), the winner is the opposite of last_conflict_winner.
  - last_conflict_winner updates only on a conflict cycle. Reset value is READ, so the first conflict goes to WRITE.
- Issue is combinational, with zero added latency:
  - read_vld = grant_rd; write_vld = grant_wr.
  - rd_req_rdy = grant_rd; wr_req_rdy = grant_wr.
  - read_cmd, write_cmd and wr_data are driven straight from the request inputs. They are don't-care when the matching valid is low, but must be driven (no X).
- Read return path:
  - The tag and read_vld are registered (tag_d, inflight).
  - The cycle after issue, rd_data and tag_d are pushed into the FIFO unconditionally. The credit rule guarantees space.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and a count of log2(RSP_DEPTH)+1 bits.
  - Head is combinationally visible: rsp_vld = (count != 0).
  - Pop when rsp_vld && rsp_rdy.
  - Simultaneous push and pop leaves count unchanged, including when count == RSP_DEPTH-1 or count == 1.
  - Pointers wrap modulo RSP_DEPTH.
- Full boundary: with count == RSP_DEPTH-1 and inflight == 1, reads are blocked. A pop in the same cycle does not unblock until the next cycle, because credit is computed from registered state only.
- Reset:
  - All of these clear to 0: outputs rd_req_rdy, wr_req_rdy, read_vld, write_vld, rsp_vld; pointers; count; inflight; tag_d.
  - last_conflict_winner resets to READ.
  - Reset mid-operation discards any in-flight read; the SRAM data returning the next cycle is not pushed.
- Invariant: !(read_vld && write_vld) every cycle.

Optional Feature:
- Macro: SRAM_REQ_ARB_PERF_CNT_EN.
- When defined, adds two output ports:
  - conflict_cnt[CNT_W-1:0]: increments on each conflict cycle.
  - rd_credit_stall_cnt[CNT_W-1:0]: increments when rd_req_vld && !credit_ok.
  - Both saturate at all-ones and clear on rst.
- When undefined, neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- sram_inst_cmd_t is reused from vector_cache_pkg.
- Add an arbiter-winner enum (ARB_RD, ARB_WR) to vector_cache_pkg.
- One natural sub-module: sram_rsp_fifo, parameterised by depth and width, holding data plus tag and exposing its count.

Test Plan:
- Write then read: write addr 9'h010, mode 0, byte_sel 2'b01, data 32'hDEADBEEF; then read the same command with tag 4'h3. Expect rsp_vld two cycles after the read grant, with rsp_data 32'hDEADBEEF and rsp_tag 4'h3.
- Continuous conflict: both requests valid for 6 cycles. Grants alternate W,R,W,R,W,R, read_vld and write_vld are never both 1, and conflict_cnt = 6 with the feature enabled.
- Credit backpressure: rsp_rdy = 0 and reads issued back-to-back. Exactly 4 grants, then rd_req_rdy stays 0. Raise rsp_rdy: a new grant occurs the cycle after the first pop, and tags come out in order 0,1,2,3.
- Simultaneous push/pop at count 3: rsp_rdy = 1 while a read returns. Count stays 3 and data stays in order.
- Reset mid-flight: assert rst the cycle after a read grant. The FIFO is empty after reset, rsp_vld = 0, and no stale response ever appears.
- Byte mode: read with mode = 1, byte_sel = 2'b10. read_cmd matches the request exactly in the grant cycle, and no write is issued.
